// File: rtl/e_gpu_icache_rsp_pkg.sv
// Shared types and sizing helpers for the instruction-cache responder.
package e_gpu_icache_rsp_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 8;

    // Buffered response payload for the default configuration.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } rsp_entry_t;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int unsigned credit_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/icache_rsp_fifo.sv
// Generic synchronous FIFO; pointers carry an extra MSB so full and empty
// can be told apart when the index bits match.
module icache_rsp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en_c, rd_en_c;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_en_c = push_i && !full_o;
    assign rd_en_c = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_c) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_en_c) rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk_i) begin
        if (wr_en_c) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/icache_responder.sv
// Instruction-cache fetch responder: tracks outstanding tags and buffers memory
// data so the pipeline can stall responses. Optional E_GPU_ICACHE_RSP_BYPASS_EN.
module icache_responder #(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              icache_req_valid_i,
    input  logic [ADDR_W-1:0] icache_req_addr_i,
    input  logic [TAG_W-1:0]  icache_req_tag_i,
    output logic              icache_req_ready_o,
    output logic              icache_rsp_valid_o,
    output logic [DATA_W-1:0] icache_rsp_data_o,
    output logic [TAG_W-1:0]  icache_rsp_tag_o,
    input  logic              icache_rsp_ready_i,
    output logic              mem_req_valid_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_req_ready_i,
    input  logic              mem_rsp_valid_i,
    input  logic [DATA_W-1:0] mem_rsp_data_i,
    output logic              err_o
);

    import e_gpu_icache_rsp_pkg::*;

    localparam int unsigned CW = credit_w(DEPTH);
    localparam int unsigned RW = DATA_W + TAG_W;

    logic [CW-1:0]     credits_q, credits_d;
    logic              err_q, err_d;
    logic              has_credit_c, req_fire_c, mem_rsp_take_c;
    logic              rsp_pop_c, rsp_push_c, bypass_c, credit_ret_c;
    logic              tag_full, tag_empty;
    logic [TAG_W-1:0]  tag_head;
    logic              rsp_full, rsp_empty;
    logic [RW-1:0]     rsp_head;

    // Credits cover every in-flight and buffered fetch, so the FIFOs never overflow.
    assign has_credit_c       = (credits_q != '0) && !tag_full && !rsp_full && !rst_i;
    assign icache_req_ready_o = mem_req_ready_i && has_credit_c;
    assign mem_req_valid_o    = icache_req_valid_i && has_credit_c;
    assign mem_req_addr_o     = icache_req_addr_i;

    assign req_fire_c     = icache_req_valid_i && icache_req_ready_o;
    assign mem_rsp_take_c = mem_rsp_valid_i && !tag_empty;

`ifdef E_GPU_ICACHE_RSP_BYPASS_EN
    // Forward memory data straight out only when nothing older is buffered.
    assign bypass_c           = mem_rsp_take_c && rsp_empty && icache_rsp_ready_i && !rst_i;
    assign icache_rsp_valid_o = !rsp_empty || bypass_c;
    assign icache_rsp_data_o  = rsp_empty ? mem_rsp_data_i : rsp_head[RW-1:TAG_W];
    assign icache_rsp_tag_o   = rsp_empty ? tag_head : rsp_head[TAG_W-1:0];
`else
    assign bypass_c           = 1'b0;
    assign icache_rsp_valid_o = !rsp_empty;
    assign icache_rsp_data_o  = rsp_head[RW-1:TAG_W];
    assign icache_rsp_tag_o   = rsp_head[TAG_W-1:0];
`endif

    assign rsp_pop_c    = icache_rsp_ready_i && !rsp_empty;
    assign rsp_push_c   = mem_rsp_take_c && !bypass_c;
    assign credit_ret_c = rsp_pop_c || bypass_c;
    assign err_o        = err_q;

    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        if (req_fire_c && !credit_ret_c) begin
            credits_d = credits_q - CW'(1);
        end else if (!req_fire_c && credit_ret_c) begin
            credits_d = credits_q + CW'(1);
        end
        if (mem_rsp_valid_i && tag_empty) err_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            credits_q <= CW'(DEPTH);
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    icache_rsp_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (req_fire_c),
        .data_i  (icache_req_tag_i),
        .pop_i   (mem_rsp_take_c),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .head_o  (tag_head)
    );

    icache_rsp_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rsp_push_c),
        .data_i  ({mem_rsp_data_i, tag_head}),
        .pop_i   (rsp_pop_c),
        .full_o  (rsp_full),
        .empty_o (rsp_empty),
        .head_o  (rsp_head)
    );

endmodule

// File: tb/tb_icache_responder.sv
// Scoreboard bench for icache_responder with an in-order fixed-latency memory model.
module tb_icache_responder;

    import e_gpu_icache_rsp_pkg::*;

    localparam int unsigned ADDR_W = 30;

    logic              clk, rst;
    logic              icache_req_valid_i;
    logic [ADDR_W-1:0] icache_req_addr_i;
    logic [TAG_W-1:0]  icache_req_tag_i;
    logic              icache_req_ready_o;
    logic              icache_rsp_valid_o;
    logic [DATA_W-1:0] icache_rsp_data_o;
    logic [TAG_W-1:0]  icache_rsp_tag_o;
    logic              icache_rsp_ready_i;
    logic              mem_req_valid_o;
    logic [ADDR_W-1:0] mem_req_addr_o;
    logic              mem_req_ready_i;
    logic              mem_rsp_valid_i;
    logic [DATA_W-1:0] mem_rsp_data_i;
    logic              err_o;

    icache_responder #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .TAG_W (TAG_W), .DEPTH (4)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .icache_req_valid_i (icache_req_valid_i),
        .icache_req_addr_i  (icache_req_addr_i),
        .icache_req_tag_i   (icache_req_tag_i),
        .icache_req_ready_o (icache_req_ready_o),
        .icache_rsp_valid_o (icache_rsp_valid_o),
        .icache_rsp_data_o  (icache_rsp_data_o),
        .icache_rsp_tag_o   (icache_rsp_tag_o),
        .icache_rsp_ready_i (icache_rsp_ready_i),
        .mem_req_valid_o    (mem_req_valid_o),
        .mem_req_addr_o     (mem_req_addr_o),
        .mem_req_ready_i    (mem_req_ready_i),
        .mem_rsp_valid_i    (mem_rsp_valid_i),
        .mem_rsp_data_i     (mem_rsp_data_i),
        .err_o              (err_o)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                due;
    } mreq_t;

    rsp_entry_t exp_q[$];
    mreq_t      mem_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         mem_lat  = 3;
    logic       spur_req = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DATA_W-1:0] mdata(input logic [ADDR_W-1:0] a);
        return 32'hDEADBEEF ^ ((32'(a) - 32'h100) * 32'h9E3779B1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // In-order memory: answers each accepted read mem_lat cycles later, never stalls.
    initial begin
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (spur_req) begin
                mem_rsp_valid_i = 1'b1;
                mem_rsp_data_i  = 32'h0BAD0BAD;
                spur_req        = 1'b0;
            end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                mem_rsp_valid_i = 1'b1;
                mem_rsp_data_i  = mdata(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                mem_rsp_valid_i = 1'b0;
            end
        end
    end

    // Scoreboard: push on request fire, pop and compare on response handshake.
    initial begin
        rsp_entry_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (icache_rsp_valid_o && icache_rsp_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", 64'(icache_rsp_tag_o) | 64'h100, 64'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_data", 64'(icache_rsp_data_o), 64'(e.data));
                        chk("rsp_tag", 64'(icache_rsp_tag_o), 64'(e.tag));
                    end
                end
                if (icache_req_valid_i && icache_req_ready_o) begin
                    exp_q.push_back('{data: mdata(icache_req_addr_i), tag: icache_req_tag_i});
                    mem_q.push_back('{addr: icache_req_addr_i, due: cyc + mem_lat});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send_req(input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t);
        logic fired;
        fired = 1'b0;
        icache_req_valid_i = 1'b1;
        icache_req_addr_i  = a;
        icache_req_tag_i   = t;
        for (int i = 0; i < 200 && !fired; i++) begin
            @(negedge clk);
            fired = icache_req_ready_o;
            step();
        end
        icache_req_valid_i = 1'b0;
        if (!fired) chk("req_timeout", 64'h0, 64'h1);
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && (mem_q.size() == 0);
        end
        if (!done) chk("drain_timeout", 64'(exp_q.size()), 64'h0);
        step();
    endtask

    initial begin
        logic seen;
        rst                = 1'b1;
        icache_req_valid_i = 1'b1;
        icache_req_addr_i  = '0;
        icache_req_tag_i   = '0;
        icache_rsp_ready_i = 1'b1;
        mem_req_ready_i    = 1'b1;

        // Reset state, with a request pending to show ready/valid are forced low.
        step();
        chk("rst_req_ready", 64'(icache_req_ready_o), 64'h0);
        chk("rst_mem_valid", 64'(mem_req_valid_o), 64'h0);
        chk("rst_rsp_valid", 64'(icache_rsp_valid_o), 64'h0);
        chk("rst_err", 64'(err_o), 64'h0);
        chk("rst_credits", 64'(dut.credits_q), 64'd4);
        step();
        icache_req_valid_i = 1'b0;
        rst = 1'b0;
        step();

        // Single fetch and response latency.
        mem_lat = 3;
        send_req(30'h100, 8'h05);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = mem_rsp_valid_i;
        end
        if (!seen) chk("single_mem_rsp", 64'h0, 64'h1);
        else begin
`ifdef E_GPU_ICACHE_RSP_BYPASS_EN
            chk("single_lat0", 64'(icache_rsp_valid_o), 64'h1);
`else
            chk("single_lat0", 64'(icache_rsp_valid_o), 64'h0);
            @(negedge clk);
            chk("single_lat1", 64'(icache_rsp_valid_o), 64'h1);
`endif
        end
        wait_drain();
        chk("single_credits", 64'(dut.credits_q), 64'd4);

        // Back-to-back until credits run out, then release the pipeline.
        icache_rsp_ready_i = 1'b0;
        for (int t = 1; t <= 4; t++) send_req(30'h110 + 30'(t), 8'(t));
        icache_req_valid_i = 1'b1;
        icache_req_addr_i  = 30'h120;
        icache_req_tag_i   = 8'h05;
        @(negedge clk);
        chk("full_req_ready", 64'(icache_req_ready_o), 64'h0);
        chk("full_mem_valid", 64'(mem_req_valid_o), 64'h0);
        chk("full_credits", 64'(dut.credits_q), 64'd0);
        step();
        repeat (6) step();
        icache_rsp_ready_i = 1'b1;
        send_req(30'h120, 8'h05);
        wait_drain();

        // Memory stall blocks acceptance.
        mem_req_ready_i    = 1'b0;
        icache_req_valid_i = 1'b1;
        icache_req_addr_i  = 30'h300;
        icache_req_tag_i   = 8'h33;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_req_ready", 64'(icache_req_ready_o), 64'h0);
            chk("stall_mem_valid", 64'(mem_req_valid_o), 64'h1);
            step();
        end
        chk("stall_credits", 64'(dut.credits_q), 64'd4);
        mem_req_ready_i = 1'b1;
        send_req(30'h300, 8'h33);
        chk("stall_one_accept", 64'(dut.credits_q), 64'd3);
        wait_drain();

        // Concurrent fire and pop at credits==1.
        mem_lat = 1;
        icache_rsp_ready_i = 1'b0;
        for (int t = 0; t < 3; t++) send_req(30'h400 + 30'(t), 8'h41 + 8'(t));
        repeat (5) step();
        chk("conc_setup_credits", 64'(dut.credits_q), 64'd1);
        icache_rsp_ready_i = 1'b1;
        icache_req_valid_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            icache_req_addr_i = 30'h410 + 30'(k);
            icache_req_tag_i  = 8'h50 + 8'(k);
            @(negedge clk);
            chk("conc_fire", 64'(icache_req_ready_o), 64'h1);
            chk("conc_pop", 64'(icache_rsp_valid_o), 64'h1);
            step();
            chk("conc_credits", 64'(dut.credits_q), 64'd1);
        end
        icache_req_valid_i = 1'b0;
        wait_drain();
        chk("conc_end_credits", 64'(dut.credits_q), 64'd4);

        // Spurious memory response.
        @(negedge clk);
        spur_req = 1'b1;
        step();
        @(negedge clk);
        chk("spur_err_before", 64'(err_o), 64'h0);
        @(negedge clk);
        chk("spur_err_set", 64'(err_o), 64'h1);
        chk("spur_no_rsp", 64'(icache_rsp_valid_o), 64'h0);
        step();
        repeat (4) step();
        chk("spur_err_sticky", 64'(err_o), 64'h1);
        chk("spur_credits", 64'(dut.credits_q), 64'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("spur_err_cleared", 64'(err_o), 64'h0);

        // Reset with fetches outstanding and buffered.
        mem_lat = 3;
        icache_rsp_ready_i = 1'b0;
        for (int t = 0; t < 3; t++) send_req(30'h500 + 30'(t), 8'h06 + 8'(t));
        repeat (8) step();
        chk("midrst_pre_valid", 64'(icache_rsp_valid_o), 64'h1);
        icache_req_valid_i = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 64'(icache_rsp_valid_o), 64'h0);
        chk("midrst_req_ready", 64'(icache_req_ready_o), 64'h0);
        chk("midrst_mem_valid", 64'(mem_req_valid_o), 64'h0);
        exp_q.delete();
        mem_q.delete();
        step();
        step();
        icache_req_valid_i = 1'b0;
        rst = 1'b0;
        step();
        chk("midrst_credits", 64'(dut.credits_q), 64'd4);
        icache_rsp_ready_i = 1'b1;
        send_req(30'h200, 8'h09);
        wait_drain();
        chk("midrst_end_credits", 64'(dut.credits_q), 64'd4);
        chk("final_err", 64'(err_o), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Responder side of the L1 instruction-cache request/response protocol: accepts fetch requests (valid/addr/tag/ready) from a compute-unit pipeline and returns in-order responses (valid/data/tag/ready).
- Sits between the pipeline's icache ports and an in-order, non-backpressuring instruction memory port.
- Tracks tags of outstanding fetches and buffers returned data so the pipeline may stall responses without losing memory data.

Parameters:
- ADDR_W, 30, word-address width of fetch requests.
- DATA_W, 32, instruction word width.
- TAG_W, 8, request/response tag width.
- DEPTH, 4, max fetches in flight plus buffered; power of two, >=2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- icache_req_valid_i  in  1  fetch request valid.
- icache_req_addr_i  in  ADDR_W  fetch word address.
- icache_req_tag_i  in  TAG_W  request tag.
- icache_req_ready_o  out  1  request accepted when high with valid.
- icache_rsp_valid_o  out  1  response valid.
- icache_rsp_data_o  out  DATA_W  instruction word.
- icache_rsp_tag_o  out  TAG_W  tag of the matching request.
- icache_rsp_ready_i  in  1  pipeline accepts response.
- mem_req_valid_o  out  1  memory read request.
- mem_req_addr_o  out  ADDR_W  memory word address.
- mem_req_ready_i  in  1  memory accepts request.
- mem_rsp_valid_i  in  1  memory read data valid, in order, cannot be stalled.
- mem_rsp_data_i  in  DATA_W  memory read data.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset: asynchronous and active-high. All FIFOs empty. credits=DEPTH. err_o=0. icache_rsp_valid_o=0. icache_req_ready_o and mem_req_valid_o forced 0 while rst_i is high.
- credits = DEPTH - (in-flight + buffered responses). It is a registered counter, width $clog2(DEPTH)+1.
- Request path is combinational pass-through:
  - mem_req_valid_o = icache_req_valid_i && credits!=0.
  - icache_req_ready_o = mem_req_ready_i && credits!=0.
  - mem_req_addr_o = icache_req_addr_i.
- Request fire (valid && ready): push tag into the tag FIFO and decrement credits.
- Memory response: on mem_rsp_valid_i with the tag FIFO non-empty, pop the tag and write {data, tag} into the response FIFO.
- Response output: icache_rsp_* driven from the response FIFO head. Pop on icache_rsp_valid_o && icache_rsp_ready_i, and increment credits.
- Simultaneous request fire and response pop in the same cycle: credits unchanged.
- Simultaneous memory write and response pop: both occur; the response FIFO count is unchanged.
- Latency without the optional feature: response valid exactly 1 cycle after mem_rsp_valid_i when the FIFO was empty.
- Full case: credits==0 means ready=0 and mem_req_valid_o=0 regardless of mem_req_ready_i. The response FIFO therefore never overflows, since credits cover all in-flight data.
- Spurious response: mem_rsp_valid_i with the tag FIFO empty is dropped and sets err_o. err_o clears only on reset.
- Ordering: responses leave in request order. Tags are returned unmodified and need not be unique.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer MSB.
- Reset mid-operation: outstanding tags and buffered data are discarded. The memory side is reset in the same domain, so no stale responses are expected after reset.

Optional Feature:
- Macro: E_GPU_ICACHE_RSP_BYPASS_EN.
- Defined: when the response FIFO is empty and icache_rsp_ready_i=1, a memory response is forwarded combinationally:
  - icache_rsp_valid_o = mem_rsp_valid_i.
  - Data comes from mem_rsp_data_i; tag comes from the tag FIFO head.
  - The FIFO is not written.
  - Credits are incremented that cycle.
  - Latency 0 cycles.
- If icache_rsp_ready_i=0 or the FIFO is non-empty, the response is written to the FIFO as normal, which preserves ordering.
- Undefined: all responses pass through the FIFO, with a minimum latency of 1 cycle.

Decomposition:
- Package e_gpu_icache_rsp_pkg:
  - Typedef rsp_entry_t as a packed struct {data, tag}; widths come from the package localparams DATA_W/TAG_W defaults.
  - Credit-width function.
- Sub-module icache_rsp_fifo: generic synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty/head outputs and asynchronous active-high reset.
  - Instantiated twice: tag FIFO with WIDTH=TAG_W, and response FIFO with WIDTH=DATA_W+TAG_W.

Test Plan:
- Single fetch: req addr=0x100, tag=0x05; memory responds 3 cycles later with 0xDEADBEEF -> rsp valid 1 cycle later (0 cycles with bypass) with data=0xDEADBEEF, tag=0x05; credits return to 4.
- Back-to-back: 4 reqs with tags 1,2,3,4 and rsp_ready=0 -> 5th req sees ready=0; release rsp_ready -> tags 1,2,3,4 in order, then the 5th is accepted.
- Memory stall: mem_req_ready_i=0 with req valid -> icache_req_ready_o=0 and no tag pushed; raise ready -> single accept.
- Concurrent: with credits=1 steady, request fire and response pop in the same cycle for 20 cycles -> credits stays 1, no loss, tags in order.
- Spurious: mem_rsp_valid_i=1 with nothing outstanding -> err_o=1 next cycle and stays 1; no response emitted; reset clears it.
- Reset mid-op: 3 outstanding fetches, assert rst_i -> rsp_valid=0 immediately, credits=4 after release, next req tag 0x09 returns correctly.
